// File: rtl/ss_op_sequencer.sv
// Shadow-stack op sequencer: accepts PUSH/POPCHK/SSPRR from issue, runs one LSU
// request/grant/response at a time, and reports SSP commit or software-check fault.
module ss_op_sequencer #(
    parameter int          XLEN       = 64,
    parameter int unsigned SSCHK_TVAL = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] link_i,
    input  logic [XLEN-1:0] ssp_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            ssp_we_o,
    output logic [XLEN-1:0] ssp_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_tval_o
);

    localparam logic [XLEN-1:0] STEP     = XLEN'(XLEN / 8);
    localparam logic [XLEN-1:0] TVAL_CHK = XLEN'(SSCHK_TVAL);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;
    typedef enum logic [1:0] {OP_PUSH, OP_POPCHK, OP_SSPRR, OP_RSVD} op_e;

    state_e          state_q, state_d;
    op_e             op_q;
    logic [XLEN-1:0] link_q, ssp_q, addr_q;
    logic [XLEN-1:0] ssp_new_q, ssp_new_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic            done_q, done_d;
    logic            commit_q, commit_d;
    logic            ex_q, ex_d;
    logic            accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= OP_PUSH;
            link_q    <= '0;
            ssp_q     <= '0;
            addr_q    <= '0;
            ssp_new_q <= '0;
            tval_q    <= '0;
            done_q    <= 1'b0;
            commit_q  <= 1'b0;
            ex_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ssp_new_q <= ssp_new_d;
            tval_q    <= tval_d;
            done_q    <= done_d;
            commit_q  <= commit_d;
            ex_q      <= ex_d;
            if (accept) begin
                op_q   <= op_e'(op_i);
                link_q <= link_i;
                ssp_q  <= ssp_i;
                addr_q <= (op_e'(op_i) == OP_PUSH) ? ssp_i - STEP : ssp_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        done_d    = 1'b0;
        commit_d  = 1'b0;
        ex_d      = 1'b0;
        ssp_new_d = ssp_new_q;
        tval_d    = tval_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i && !flush_i) begin
                    accept = 1'b1;
                    unique case (op_e'(op_i))
                        OP_PUSH, OP_POPCHK: state_d = REQ;
                        OP_SSPRR:           done_d  = 1'b1;
                        OP_RSVD: begin
                            done_d = 1'b1;
                            ex_d   = 1'b1;
                            tval_d = '0;
                        end
                    endcase
                end
            end
            REQ: begin
                // A grant coinciding with a flush still leaves a response to absorb.
                if (flush_i)        state_d = mem_gnt_i ? DRAIN : IDLE;
                else if (mem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                    if (!flush_i) begin
                        done_d = 1'b1;
                        if (mem_err_i) begin
                            ex_d   = 1'b1;
                            tval_d = addr_q;
                        end else if (op_q == OP_PUSH) begin
                            commit_d  = 1'b1;
                            ssp_new_d = ssp_q - STEP;
                        end else if (mem_rdata_i == link_q) begin
                            commit_d  = 1'b1;
                            ssp_new_d = ssp_q + STEP;
                        end else begin
                            ex_d   = 1'b1;
                            tval_d = TVAL_CHK;
                        end
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_rvalid_i) state_d = IDLE;
            end
        endcase
    end

    assign ready_o     = (state_q == IDLE);
    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = (op_q == OP_PUSH);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = link_q;

    // Completion pulses are registered; a flush in their cycle squashes them.
    assign done_o      = done_q & ~flush_i;
    assign ssp_we_o    = commit_q & ~flush_i;
    assign ex_valid_o  = ex_q & ~flush_i;
    assign result_o    = ssp_q;
    assign ssp_o       = ssp_new_q;
    assign ex_tval_o   = tval_q;

endmodule
